rv32i_mem_stage: RTL and testbench
==================================

Name: rv32i_mem_stage

Overview:
- Memory-access pipeline stage between EX and WB.
- Consumes an ex_mem_payload_t through a valid/ready handshake and performs loads/stores on a req/gnt/rvalid data-memory port.
- Formats load data and produces a registered mem_wb_payload_t through a valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
ALIGN_CHECK, 1, 1: misaligned half/word accesses are trapped (no bus access); 0: addr[1:0] ignored for lane select of WORD, access always issued.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ex_valid_i  in  1  EX payload valid
ex_ready_o  out  1  stage can accept payload
ex_payload_i  in  ex_mem_payload_t  EX/MEM payload
wb_valid_o  out  1  output payload valid
wb_ready_i  in  1  WB accepts output
wb_payload_o  out  mem_wb_payload_t  MEM/WB payload (registered)
dmem_req_o  out  1  memory request
dmem_gnt_i  in  1  request accepted
dmem_addr_o  out  32  word-aligned address {alu_result[31:2],2'b00}
dmem_we_o  out  1  1 = store
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load data word
misalign_o  out  1  one-cycle pulse: misaligned access trapped

Behaviour:
- One clock; reset is asynchronous and active-low (rst_ni).
- Reset values: state IDLE; wb_valid_o=0; wb_payload_o=0; dmem_req_o=0; dmem_we_o=0; dmem_be_o=0; dmem_addr_o=0; dmem_wdata_o=0; misalign_o=0.
- FSM states: IDLE, REQ, RESP. ex_ready_o = (state==IDLE) && (!wb_valid_o || wb_ready_i).
- Handshake: a transfer occurs when valid&&ready on a cycle edge. wb_valid_o holds with a stable payload until wb_ready_i. Clear wb_valid_o on consume unless a new result loads that same cycle.
- IDLE accept of a non-memory op (mem_read=0, mem_write=0): next cycle wb_valid_o=1. Payload fields pc, pc_plus4, alu_result, rd_addr, wb_sel, reg_write copy through; mem_rdata=0.
- IDLE accept of a memory op: latch payload, go to REQ. mem_write=1 has priority if mem_read and mem_write are both set.
- Misaligned op (ALIGN_CHECK=1): HALF with addr[0]=1, or WORD with addr[1:0]!=0.
  - Stay IDLE; no request.
  - misalign_o=1 for the next cycle only.
  - Output produced as for a non-memory op, with reg_write forced 0.
- REQ: dmem_req_o=1 with address/we/be/wdata held stable from registers until dmem_gnt_i.
  - Grant on a store: go IDLE; wb_valid_o=1 next cycle.
  - Grant on a load: drop dmem_req_o, go RESP.
- RESP: wait any number of cycles for dmem_rvalid_i. On rvalid, capture the formatted data into mem_rdata, wb_valid_o=1 next cycle, go IDLE.
- dmem_rvalid_i outside RESP, and dmem_gnt_i outside REQ, are ignored.
- Store formatting:
  - be = mem_size_to_be(mem_size, addr[1:0]).
  - BYTE wdata = {4{rs2[7:0]}}; HALF = {2{rs2[15:0]}}; WORD = rs2.
- Load formatting (lane = addr[1:0]):
  - BYTE: byte (rdata >> 8*lane), sign-extended unless mem_unsigned.
  - HALF: rdata[31:16] if addr[1], else rdata[15:0], sign/zero-extended the same way.
  - WORD: rdata.
- Latency:
  - Accept at T, gnt at T+1: store output valid at T+2.
  - Load with rvalid at T+2: output valid at T+3.
  - Non-memory op: output valid at T+1.
- At most one outstanding access. No new accept until the current op reaches the output register.
- Reset mid-access: state returns to IDLE and dmem_req_o drops immediately (async). A late rvalid is ignored.

Test Plan:
- ADD result alu=0x1234, rd=5, wb_ready_i=1 -> wb_valid_o at T+1, alu_result=0x1234, rd_addr=5, no dmem_req_o.
- LB addr=0x103, rdata=0x80AABBCC, gnt at T+1, rvalid at T+3 -> mem_rdata=0xFFFFFF80 at T+4. Same with LBU -> 0x00000080.
- SH addr=0x102, rs2=0xDEADBEEF -> dmem_addr_o=0x100, be=4'b1100, wdata=0xBEEFBEEF, dmem_we_o=1. With gnt delayed 3 cycles, request signals stay stable.
- LW addr=0x101 (ALIGN_CHECK=1) -> misalign_o pulse, no dmem_req_o, output reg_write=0.
- Back-to-back ADD/ADD with wb_ready_i low for 2 cycles -> first payload held stable, ex_ready_o=0, second accepted on the consume cycle, no loss or duplication.
- Load in RESP, rst_ni asserted, then rvalid pulses after reset release -> state IDLE, wb_valid_o stays 0.

Source files
------------

// File: rtl/rv32i_mem_stage_if.sv
// Shared MEM-stage types and the data-memory bus interface.
// master = the MEM stage driving requests, slave = the data memory answering them.
package rv32i_mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        mem_size_e   mem_size;
        logic        mem_unsigned;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic        reg_write;
    } mem_wb_payload_t;

    // Halfwords pick their lane from addr[1] only, so an unchecked odd
    // halfword still lands on a legal lane pair.
    function automatic logic [3:0] mem_size_to_be(input mem_size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << lane;
            MEM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

interface rv32i_mem_stage_if;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: issues one load/store at a time on a req/gnt/rvalid
// bus and hands a registered MEM/WB payload to writeback.
module rv32i_mem_stage
    import rv32i_mem_stage_pkg::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  ex_mem_payload_t     ex_payload_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output mem_wb_payload_t     wb_payload_o,
    rv32i_mem_stage_if.master   dmem,
    output logic                misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e          state_q;
    logic            wb_valid_q;
    mem_wb_payload_t wb_payload_q;
    mem_wb_payload_t res_q;
    logic            req_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            misalign_q;
    mem_size_e       size_q;
    logic            uns_q;
    logic [1:0]      lane_q;

    logic            accept;
    logic            ex_is_mem;
    logic            ex_misaligned;
    logic [1:0]      ex_lane;
    logic [31:0]     ex_wdata;
    mem_wb_payload_t ex_pass;
    mem_wb_payload_t rsp_payload;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;

    assign ex_ready_o = (state_q == IDLE) && (!wb_valid_q || wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o;

    always_comb begin
        ex_lane       = ex_payload_i.alu_result[1:0];
        ex_is_mem     = ex_payload_i.mem_read | ex_payload_i.mem_write;
        ex_misaligned = 1'b0;
        if ((ALIGN_CHECK != 0) && ex_is_mem) begin
            case (ex_payload_i.mem_size)
                MEM_HALF: ex_misaligned = ex_lane[0];
                MEM_WORD: ex_misaligned = (ex_lane != 2'b00);
                default:  ex_misaligned = 1'b0;
            endcase
        end

        case (ex_payload_i.mem_size)
            MEM_BYTE: ex_wdata = {4{ex_payload_i.rs2_data[7:0]}};
            MEM_HALF: ex_wdata = {2{ex_payload_i.rs2_data[15:0]}};
            default:  ex_wdata = ex_payload_i.rs2_data;
        endcase

        // A trapped access still retires, but must never write the register file.
        ex_pass            = '0;
        ex_pass.pc         = ex_payload_i.pc;
        ex_pass.pc_plus4   = ex_payload_i.pc_plus4;
        ex_pass.alu_result = ex_payload_i.alu_result;
        ex_pass.rd_addr    = ex_payload_i.rd_addr;
        ex_pass.wb_sel     = ex_payload_i.wb_sel;
        ex_pass.reg_write  = ex_payload_i.reg_write & ~ex_misaligned;
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata_i[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
        case (size_q)
            MEM_BYTE: ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            MEM_HALF: ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
            default:  ld_data = dmem.dmem_rdata_i;
        endcase
        rsp_payload           = res_q;
        rsp_payload.mem_rdata = ld_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wb_valid_q   <= 1'b0;
            wb_payload_q <= '0;
            res_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            misalign_q   <= 1'b0;
            size_q       <= MEM_BYTE;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
        end else begin
            misalign_q <= 1'b0;
            // A result produced below in the same cycle overrides this clear.
            if (wb_valid_q && wb_ready_i) begin
                wb_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!ex_is_mem || ex_misaligned) begin
                            wb_valid_q   <= 1'b1;
                            wb_payload_q <= ex_pass;
                            misalign_q   <= ex_misaligned;
                        end else begin
                            res_q   <= ex_pass;
                            size_q  <= ex_payload_i.mem_size;
                            uns_q   <= ex_payload_i.mem_unsigned;
                            lane_q  <= ex_lane;
                            req_q   <= 1'b1;
                            we_q    <= ex_payload_i.mem_write;
                            be_q    <= mem_size_to_be(ex_payload_i.mem_size, ex_lane);
                            addr_q  <= {ex_payload_i.alu_result[31:2], 2'b00};
                            wdata_q <= ex_wdata;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt_i) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            wb_valid_q   <= 1'b1;
                            wb_payload_q <= res_q;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem.dmem_rvalid_i) begin
                        wb_valid_q   <= 1'b1;
                        wb_payload_q <= rsp_payload;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_valid_o        = wb_valid_q;
    assign wb_payload_o      = wb_payload_q;
    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign misalign_o        = misalign_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Bench for rv32i_mem_stage: directed scenarios plus a randomized run against a
// byte-addressed reference memory with a randomly stalling bus responder.
module tb_rv32i_mem_stage;
    import rv32i_mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            ex_valid, ex_ready, wb_valid, wb_ready, misalign;
    ex_mem_payload_t ex_payload;
    mem_wb_payload_t wb_payload;

    rv32i_mem_stage_if dmem();

    rv32i_mem_stage #(.ALIGN_CHECK(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ex_valid_i   (ex_valid),
        .ex_ready_o   (ex_ready),
        .ex_payload_i (ex_payload),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_payload_o (wb_payload),
        .dmem         (dmem),
        .misalign_o   (misalign)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Directed tests drive d_*, the random responder drives r_*.
    logic        resp_en = 1'b0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        r_gnt = 1'b0, r_rvalid = 1'b0;
    logic [31:0] r_rdata = 32'h0;
    assign dmem.dmem_gnt_i    = resp_en ? r_gnt    : d_gnt;
    assign dmem.dmem_rvalid_i = resp_en ? r_rvalid : d_rvalid;
    assign dmem.dmem_rdata_i  = resp_en ? r_rdata  : d_rdata;

    logic [31:0] mem [0:63];
    logic [7:0]  ref_mem [0:255];

    int          gcnt = 0, rcnt = 0, gnt_dly = 0, rv_dly = 0;
    bit          pend_load = 0;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_be;
    logic        g_we;

    always @(negedge clk) begin
        if (!resp_en) begin
            r_gnt = 1'b0; r_rvalid = 1'b0; pend_load = 0; gcnt = 0;
        end else begin
            r_rvalid = 1'b0;
            r_rdata  = $urandom;
            if (r_gnt) begin
                r_gnt = 1'b0;
                gcnt  = 0;
                if (g_we) begin
                    for (int b = 0; b < 4; b++)
                        if (g_be[b]) mem[g_addr[7:2]][8*b +: 8] = g_wdata[8*b +: 8];
                end else begin
                    pend_load = 1; rcnt = 0; rv_dly = $urandom_range(0, 3);
                end
            end else if (dmem.dmem_req_o) begin
                if (gcnt >= gnt_dly) begin
                    r_gnt = 1'b1;
                    g_addr = dmem.dmem_addr_o; g_wdata = dmem.dmem_wdata_o;
                    g_be = dmem.dmem_be_o; g_we = dmem.dmem_we_o;
                    gnt_dly = $urandom_range(0, 3);
                end else begin
                    gcnt++;
                end
            end
            if (pend_load) begin
                if (rcnt >= rv_dly) begin
                    r_rvalid = 1'b1; r_rdata = mem[g_addr[7:2]]; pend_load = 0;
                end else begin
                    rcnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_payload_t mk(input logic rd_, input logic wr_, input mem_size_e sz,
                                           input logic uns, input logic [31:0] alu,
                                           input logic [31:0] rs2, input logic [4:0] rd, input logic rw);
        ex_mem_payload_t p;
        p.pc           = $urandom & 32'hFFFF_FFFC;
        p.pc_plus4     = p.pc + 32'd4;
        p.alu_result   = alu;
        p.rs2_data     = rs2;
        p.rd_addr      = rd;
        p.wb_sel       = 2'($urandom_range(0, 3));
        p.reg_write    = rw;
        p.mem_read     = rd_;
        p.mem_write    = wr_;
        p.mem_size     = sz;
        p.mem_unsigned = uns;
        return p;
    endfunction

    function automatic mem_wb_payload_t expect_wb(input ex_mem_payload_t p, input logic [31:0] rdata,
                                                  input logic rw);
        mem_wb_payload_t e;
        e.pc = p.pc; e.pc_plus4 = p.pc_plus4; e.alu_result = p.alu_result;
        e.mem_rdata = rdata; e.rd_addr = p.rd_addr; e.wb_sel = p.wb_sel; e.reg_write = rw;
        return e;
    endfunction

    task automatic test_reset();
        ex_valid = 0; ex_payload = '0; wb_ready = 0;
        d_gnt = 0; d_rvalid = 0; d_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_checks++; if (wb_payload !== '0) begin n_fail++; $display("FAIL reset_wb_payload got %h want 0", wb_payload); end
        n_checks++; if (dmem.dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dmem.dmem_req_o); end
        n_checks++; if (dmem.dmem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", dmem.dmem_we_o); end
        n_checks++; if (dmem.dmem_be_o !== 4'b0) begin n_fail++; $display("FAIL reset_be got %b want 0000", dmem.dmem_be_o); end
        n_checks++; if (dmem.dmem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", dmem.dmem_addr_o); end
        n_checks++; if (dmem.dmem_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", dmem.dmem_wdata_o); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", misalign); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
        $display("test_reset done");
    endtask

    task automatic test_alu();
        ex_mem_payload_t p;
        mem_wb_payload_t e;
        wb_ready = 1;
        p = mk(0, 0, MEM_WORD, 0, 32'h1234, 32'hAAAA5555, 5'd5, 1);
        e = expect_wb(p, 32'h0, 1);
        ex_payload = p; ex_valid = 1;
        #1;
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got %b want 1", ex_ready); end
        tick(); ex_valid = 0;
        n_checks++; if (wb_valid !== 1'b1 || wb_payload !== e) begin n_fail++; $display("FAIL alu_out valid=%b payload=%h want valid=1 payload=%h", wb_valid, wb_payload, e); end
        n_checks++; if (dmem.dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL alu_no_req got %b want 0", dmem.dmem_req_o); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_consumed wb_valid=%b want 0", wb_valid); end
        $display("test_alu ADD alu=%h rd=%0d", e.alu_result, e.rd_addr);
    endtask

    task automatic do_lb(input logic uns, input logic [31:0] want);
        ex_mem_payload_t p;
        mem_wb_payload_t e;
        wb_ready = 1;
        p = mk(1, 0, MEM_BYTE, uns, 32'h103, 32'h0, 5'd9, 1);
        e = expect_wb(p, want, 1);
        ex_payload = p; ex_valid = 1;
        tick(); ex_valid = 0;
        n_checks++; if ({dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_be_o, dmem.dmem_addr_o} !== {1'b1, 1'b0, 4'b1000, 32'h100})
            begin n_fail++; $display("FAIL lb_req req=%b we=%b be=%b addr=%h want 1 0 1000 00000100", dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_be_o, dmem.dmem_addr_o); end
        d_gnt = 1;
        tick(); d_gnt = 0;
        n_checks++; if (dmem.dmem_req_o !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_after_gnt req=%b wb_valid=%b want 0 0", dmem.dmem_req_o, wb_valid); end
        tick();
        d_rvalid = 1; d_rdata = 32'h80AABBCC;
        tick(); d_rvalid = 0; d_rdata = 32'h0;
        n_checks++; if (wb_valid !== 1'b1 || wb_payload !== e) begin n_fail++; $display("FAIL lb_out uns=%b valid=%b payload=%h want valid=1 payload=%h", uns, wb_valid, wb_payload, e); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_consumed wb_valid=%b want 0", wb_valid); end
        $display("test_load %s addr=103 rdata=80AABBCC mem_rdata=%h", uns ? "LBU" : "LB", wb_payload.mem_rdata);
    endtask

    task automatic test_load();
        do_lb(0, 32'hFFFF_FF80);
        do_lb(1, 32'h0000_0080);
    endtask

    task automatic test_store();
        ex_mem_payload_t p;
        mem_wb_payload_t e;
        wb_ready = 1;
        p = mk(0, 1, MEM_HALF, 0, 32'h102, 32'hDEADBEEF, 5'd3, 0);
        e = expect_wb(p, 32'h0, 0);
        ex_payload = p; ex_valid = 1;
        tick(); ex_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_be_o, dmem.dmem_addr_o, dmem.dmem_wdata_o} !== {1'b1, 1'b1, 4'b1100, 32'h100, 32'hBEEFBEEF})
                begin n_fail++; $display("FAIL sh_req cyc%0d req=%b we=%b be=%b addr=%h wdata=%h want 1 1 1100 00000100 beefbeef", i, dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_be_o, dmem.dmem_addr_o, dmem.dmem_wdata_o); end
            if (i < 3) tick();
        end
        d_gnt = 1;
        tick(); d_gnt = 0;
        n_checks++; if (dmem.dmem_req_o !== 1'b0 || wb_valid !== 1'b1 || wb_payload !== e)
            begin n_fail++; $display("FAIL sh_done req=%b valid=%b payload=%h want 0 1 %h", dmem.dmem_req_o, wb_valid, wb_payload, e); end
        tick();
        $display("test_store SH addr=102 rs2=deadbeef gnt after 3 stall cycles");
    endtask

    task automatic test_misalign();
        ex_mem_payload_t p;
        mem_wb_payload_t e;
        wb_ready = 1;
        p = mk(1, 0, MEM_WORD, 0, 32'h101, 32'h0, 5'd12, 1);
        e = expect_wb(p, 32'h0, 0);
        ex_payload = p; ex_valid = 1;
        tick(); ex_valid = 0;
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got %b want 1", misalign); end
        n_checks++; if (dmem.dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_req got %b want 0", dmem.dmem_req_o); end
        n_checks++; if (wb_valid !== 1'b1 || wb_payload !== e) begin n_fail++; $display("FAIL mis_out valid=%b payload=%h want 1 %h", wb_valid, wb_payload, e); end
        tick();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle got %b want 0", misalign); end
        n_checks++; if (dmem.dmem_req_o !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL mis_after req=%b valid=%b want 0 0", dmem.dmem_req_o, wb_valid); end
        $display("test_misalign LW addr=101 trapped");
    endtask

    task automatic test_back_to_back();
        ex_mem_payload_t p1, p2;
        mem_wb_payload_t e1, e2;
        p1 = mk(0, 0, MEM_BYTE, 0, 32'h1, 32'h0, 5'd1, 1);
        p2 = mk(0, 0, MEM_BYTE, 0, 32'h2, 32'h0, 5'd2, 1);
        e1 = expect_wb(p1, 32'h0, 1);
        e2 = expect_wb(p2, 32'h0, 1);
        wb_ready = 0;
        ex_payload = p1; ex_valid = 1;
        tick();
        ex_payload = p2;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (wb_valid !== 1'b1 || wb_payload !== e1) begin n_fail++; $display("FAIL b2b_hold cyc%0d valid=%b payload=%h want 1 %h", i, wb_valid, wb_payload, e1); end
            n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall cyc%0d ex_ready=%b want 0", i, ex_ready); end
            if (i == 0) tick();
        end
        wb_ready = 1;
        #1;
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_consume got %b want 1", ex_ready); end
        tick(); ex_valid = 0;
        n_checks++; if (wb_valid !== 1'b1 || wb_payload !== e2) begin n_fail++; $display("FAIL b2b_second valid=%b payload=%h want 1 %h", wb_valid, wb_payload, e2); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup wb_valid=%b want 0", wb_valid); end
        $display("test_back_to_back two ADDs across a 2-cycle WB stall");
    endtask

    task automatic test_reset_mid();
        wb_ready = 1;
        // store caught in REQ: the request must drop as soon as reset asserts
        ex_payload = mk(0, 1, MEM_WORD, 0, 32'h40, 32'h12345678, 5'd4, 0); ex_valid = 1;
        tick(); ex_valid = 0;
        rst_n = 0;
        #1;
        n_checks++; if (dmem.dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_drop got %b want 0", dmem.dmem_req_o); end
        tick(); rst_n = 1;
        tick();
        // load caught in RESP, with a late rvalid after reset release
        ex_payload = mk(1, 0, MEM_WORD, 0, 32'h100, 32'h0, 5'd6, 1); ex_valid = 1;
        tick(); ex_valid = 0;
        d_gnt = 1;
        tick(); d_gnt = 0;
        tick();
        rst_n = 0;
        #1;
        n_checks++; if (wb_valid !== 1'b0 || dmem.dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp valid=%b req=%b want 0 0", wb_valid, dmem.dmem_req_o); end
        tick(); rst_n = 1;
        tick();
        d_rvalid = 1; d_rdata = 32'hCAFEF00D;
        tick(); d_rvalid = 0; d_rdata = 32'h0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid wb_valid=%b want 0", wb_valid); end
        n_checks++; if (ex_ready !== 1'b1 || dmem.dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle ex_ready=%b req=%b want 1 0", ex_ready, dmem.dmem_req_o); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid2 wb_valid=%b want 0", wb_valid); end
        $display("test_reset_mid reset in REQ and RESP, late rvalid ignored");
    endtask

    // Reference: byte-addressed little-endian memory; each accepted op is
    // resolved immediately because only one access is ever in flight.
    function automatic mem_wb_payload_t model_op(input ex_mem_payload_t p, output bit mis);
        mem_wb_payload_t e;
        bit          is_mem;
        int          nbytes;
        logic [7:0]  a;
        logic [31:0] v;
        is_mem = p.mem_read || p.mem_write;
        nbytes = (p.mem_size == MEM_BYTE) ? 1 : (p.mem_size == MEM_HALF) ? 2 : 4;
        a      = p.alu_result[7:0];
        mis    = is_mem && ((a % nbytes) != 0);
        e      = expect_wb(p, 32'h0, p.reg_write && !mis);
        if (is_mem && !mis) begin
            if (p.mem_write) begin
                for (int i = 0; i < nbytes; i++) ref_mem[a + 8'(i)] = 8'(p.rs2_data >> (8 * i));
            end else begin
                v = 32'h0;
                for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[a + 8'(i)]) << (8 * i));
                if (!p.mem_unsigned && nbytes < 4 && v[8 * nbytes - 1])
                    v = v | ~((32'h1 << (8 * nbytes)) - 32'h1);
                e.mem_rdata = v;
            end
        end
        return e;
    endfunction

    function automatic ex_mem_payload_t rand_op();
        int kind;
        logic [31:0] a;
        mem_size_e sz;
        kind = $urandom_range(0, 9);
        sz   = mem_size_e'($urandom_range(0, 2));
        a    = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        if (kind < 3) return mk(0, 0, sz, 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
        return mk(kind < 6 || kind == 9, kind >= 6, sz, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
    endfunction

    task automatic test_random(input int n_ops);
        mem_wb_payload_t exp_q[$];
        mem_wb_payload_t e, prev;
        ex_mem_payload_t cur;
        bit cur_valid = 0, mis_next = 0, mis, hold_prev = 0;
        int issued = 0, done = 0, cyc = 0;
        for (int w = 0; w < 64; w++) begin
            logic [31:0] word;
            word = $urandom;
            mem[w] = word;
            for (int b = 0; b < 4; b++) ref_mem[4 * w + b] = word[8 * b +: 8];
        end
        gnt_dly = 0;
        resp_en = 1;
        while (done < n_ops && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            n_checks++; if (misalign !== mis_next) begin n_fail++; $display("FAIL rnd_misalign cyc%0d got %b want %b", cyc, misalign, mis_next); end
            if (hold_prev) begin
                n_checks++; if (wb_valid !== 1'b1 || wb_payload !== prev) begin n_fail++; $display("FAIL rnd_hold cyc%0d valid=%b payload=%h want 1 %h", cyc, wb_valid, wb_payload, prev); end
            end
            wb_ready = ($urandom_range(0, 3) != 0);
            if (!cur_valid && issued < n_ops && $urandom_range(0, 1) == 1) begin cur = rand_op(); cur_valid = 1; end
            ex_valid   = cur_valid;
            ex_payload = cur_valid ? cur : ex_mem_payload_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            #1;
            mis_next  = 0;
            hold_prev = wb_valid && !wb_ready;
            prev      = wb_payload;
            if (wb_valid && wb_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious cyc%0d unexpected output %h", cyc, wb_payload);
                end else begin
                    e = exp_q.pop_front();
                    if (wb_payload !== e) begin n_fail++; $display("FAIL rnd_out op%0d got %h want %h", done, wb_payload, e); end
                    else $display("rnd op%0d alu=%h rdata=%h rw=%b", done, e.alu_result, e.mem_rdata, e.reg_write);
                    done++;
                end
            end
            if (ex_valid && ex_ready) begin
                exp_q.push_back(model_op(cur, mis));
                mis_next  = mis;
                cur_valid = 0;
                issued++;
            end
        end
        @(negedge clk);
        ex_valid = 0; wb_ready = 1; resp_en = 0;
        n_checks++; if (done != n_ops || exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_complete done=%0d pending=%0d want done=%0d pending=0", done, exp_q.size(), n_ops); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random(250);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
